// File: rtl/mips_mem_pkg.sv
// Types and constants shared by the core-side memory blocks.
// A word is four bytes with element 0 in the most significant position.
package mips_mem_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_bytes_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } cache_state_t;

  localparam int WORD_ADDR_LSB = 2;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// synchronous write and a synchronous bulk invalidate that wins over a write.
module dcache_array
  import mips_mem_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [IDX_W-1:0] idx,
  input  logic             we,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_bytes_t      wr_data,
  input  logic             inval,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_bytes_t      rd_data
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  word_bytes_t          data  [NUM_LINES];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid <= '0;
    end else if (inval) begin
      valid <= '0;
    end else if (we) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx] <= wr_tag;
      data[idx] <= wr_data;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load hits return combinationally; load misses and all stores stall the core.
module dcache_wt
  import mips_mem_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] core_addr,
  input  logic        core_rd_en,
  input  logic        core_wr_en,
  input  word_bytes_t core_wdata,
  output word_bytes_t core_rdata,
  output logic        core_stall,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output word_bytes_t mem_wdata,
  input  word_bytes_t mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  cache_state_t     state, state_nxt;
  logic [31:0]      word_addr;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  word_bytes_t      line_data;
  logic             hit, rd_req, wr_req;
  logic             arr_we, inval;
  word_bytes_t      arr_wdata;
  logic             flush_pend, just_filled;
  logic             stall_int;
  word_bytes_t      rdata_int;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign word_addr = core_addr & 32'hFFFF_FFFC;
  assign idx       = word_addr[IDX_W+1:WORD_ADDR_LSB];
  assign tag       = word_addr[31:IDX_W+2];
  assign hit       = line_valid && (line_tag == tag);
  assign wr_req    = core_wr_en;
  assign rd_req    = core_rd_en && !core_wr_en;

  // A flush seen while busy is held until the first IDLE cycle.
  assign inval = (state == IDLE) && (flush || flush_pend);

  dcache_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst_b   (rst_b),
    .idx     (idx),
    .we      (arr_we),
    .wr_tag  (tag),
    .wr_data (arr_wdata),
    .inval   (inval),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data)
  );

  always_comb begin
    state_nxt = state;
    stall_int = 1'b0;
    rdata_int = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_wdata = core_wdata;
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          stall_int = 1'b1;
          state_nxt = WR_THRU;
          arr_we    = hit;
        end else if (rd_req) begin
          if (hit) begin
            rdata_int = line_data;
          end else begin
            stall_int = 1'b1;
            state_nxt = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall_int = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = word_addr;
        if (mem_ready) begin
          arr_we    = 1'b1;
          arr_wdata = mem_rdata;
          state_nxt = IDLE;
        end
      end
      WR_THRU: begin
        stall_int = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = core_wdata;
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While reset is held the core sees an idle, non-stalling cache.
  assign core_stall = stall_int && rst_b;
  assign core_rdata = rst_b ? rdata_int : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      flush_pend  <= 1'b0;
      just_filled <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      state       <= state_nxt;
      flush_pend  <= (state != IDLE) && (flush || flush_pend);
      just_filled <= (state == RD_MISS) && mem_ready;
      // The cycle right after a fill re-reads the same load and is not a new hit.
      if ((state == IDLE) && rd_req && hit && !just_filled) begin
        hit_count <= sat_inc(hit_count);
      end
      if ((state == IDLE) && rd_req && !hit) begin
        miss_count <= sat_inc(miss_count);
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed scenarios plus randomized traffic, checked against
// a line-level cache model and a reference memory kept in the bench.
module tb_dcache_wt;
  import mips_mem_pkg::*;

  localparam int NL = 16;

  logic        clk;
  logic        rst_b;
  logic [31:0] core_addr;
  logic        core_rd_en, core_wr_en;
  word_bytes_t core_wdata, core_rdata;
  logic        core_stall;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  word_bytes_t mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count, miss_count;

  dcache_wt #(.NUM_LINES(NL)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .core_addr (core_addr),
    .core_rd_en(core_rd_en),
    .core_wr_en(core_wr_en),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory seen by the DUT (written only through the DUT's write port).
  logic [31:0] mem_model [logic [31:0]];
  // Memory as the rules say it should be after each store.
  logic [31:0] ref_mem [logic [31:0]];
  // Cache contents as the rules predict them.
  bit          m_valid [NL];
  logic [31:0] m_addr  [NL];
  logic [31:0] m_data  [NL];
  logic [31:0] exp_hits, exp_misses;

  typedef struct {
    int          stall;
    int          en_cycles;
    logic [31:0] rdata;
    bit          saw_rd;
    bit          saw_wr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    bit          flushed;
    bit          timeout;
  } obs_t;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_A5C3;
  endfunction

  function automatic logic [31:0] dut_mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  // Applies one access to the model; returns predicted hit and load data.
  function automatic void model_access(input bit is_wr, input logic [31:0] addr,
                                       input logic [31:0] wd, input bit flushed,
                                       output bit hit, output logic [31:0] data);
    logic [31:0] wa;
    int          i;
    wa   = {addr[31:2], 2'b00};
    i    = int'(wa / 4) % NL;
    hit  = m_valid[i] && (m_addr[i] == wa);
    data = 32'h0;
    if (is_wr) begin
      ref_mem[wa] = wd;
      if (hit) m_data[i] = wd;
    end else if (hit) begin
      data = m_data[i];
      exp_hits++;
    end else begin
      data = ref_read(wa);
      exp_misses++;
      m_valid[i] = 1'b1;
      m_addr[i]  = wa;
      m_data[i]  = data;
    end
    if (flushed) model_clear();
  endfunction

  // Drives one core access starting on a negedge and plays the memory with
  // the given latency (mem_ready in the lat-th cycle of a request).
  task automatic access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input int flush_at, output obs_t o);
    int busy;
    bit done;
    busy = 0;
    done = 1'b0;
    o.stall = 0; o.en_cycles = 0; o.rdata = 32'h0; o.saw_rd = 1'b0; o.saw_wr = 1'b0;
    o.maddr = 32'h0; o.mwdata = 32'h0; o.flushed = 1'b0; o.timeout = 1'b0;
    core_addr  = addr;
    core_rd_en = !is_wr;
    core_wr_en = is_wr;
    core_wdata = wd;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      flush     = (cyc == flush_at);
      mem_ready = 1'b0;
      if (flush) o.flushed = 1'b1;
      #1;
      if (mem_rd_en || mem_wr_en) begin
        o.en_cycles++;
        o.maddr = mem_addr;
        if (mem_rd_en) o.saw_rd = 1'b1;
        if (mem_wr_en) begin
          o.saw_wr  = 1'b1;
          o.mwdata  = mem_wdata;
        end
        busy++;
        if (busy == lat) begin
          mem_ready = 1'b1;
          if (mem_wr_en) mem_model[mem_addr] = mem_wdata;
          else           mem_rdata = dut_mem_read(mem_addr);
        end
      end
      if (!core_stall) begin
        o.rdata = core_rdata;
        done    = 1'b1;
      end else begin
        o.stall++;
      end
      if (is_wr && mem_ready) done = 1'b1;
      @(negedge clk);
    end
    core_rd_en = 1'b0;
    core_wr_en = 1'b0;
    flush      = 1'b0;
    mem_ready  = 1'b0;
    if (!done) o.timeout = 1'b1;
    if (o.flushed) @(negedge clk);
  endtask

  task automatic apply_reset();
    core_rd_en = 1'b1;
    core_wr_en = 1'b0;
    core_addr  = 32'h0000_0104;
    flush      = 1'b0;
    mem_ready  = 1'b0;
    rst_b      = 1'b0;
    model_clear();
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    core_rd_en = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({core_stall, mem_rd_en, mem_wr_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl stall/rd/wr=%b expected 000", {core_stall, mem_rd_en, mem_wr_en});
    end
    checks++;
    if ({mem_addr, mem_wdata, core_rdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h expected zeros", mem_addr, mem_wdata, core_rdata);
    end
    checks++;
    if ({hit_count, miss_count} !== 64'h0) begin
      failures++;
      $display("FAIL reset_counters hit=%0d miss=%0d expected 0/0", hit_count, miss_count);
    end
    release_reset();
  endtask

  task automatic test_load_miss_hit();
    obs_t o;
    bit h;
    logic [31:0] d;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100]   = 32'hDEAD_BEEF;
    access(1'b0, 32'h100, 32'h0, 3, -1, o);
    model_access(1'b0, 32'h100, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 4 || o.timeout) begin
      failures++;
      $display("FAIL miss_stall got=%0d expected 4 timeout=%0b", o.stall, o.timeout);
    end
    checks++;
    if (o.rdata !== 32'hDEAD_BEEF || o.maddr !== 32'h100) begin
      failures++;
      $display("FAIL miss_data rdata=%h addr=%h expected deadbeef/00000100", o.rdata, o.maddr);
    end
    checks++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      failures++;
      $display("FAIL miss_counts hit=%0d miss=%0d expected 0/1", hit_count, miss_count);
    end
    access(1'b0, 32'h100, 32'h0, 3, -1, o);
    model_access(1'b0, 32'h100, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 0 || o.saw_rd || o.rdata !== 32'hDEAD_BEEF || hit_count !== 32'd1) begin
      failures++;
      $display("FAIL rehit stall=%0d rd=%0b rdata=%h hits=%0d expected 0/0/deadbeef/1",
               o.stall, o.saw_rd, o.rdata, hit_count);
    end
  endtask

  task automatic test_write_hit();
    obs_t o;
    bit h;
    logic [31:0] d;
    access(1'b1, 32'h100, 32'h1122_3344, 2, -1, o);
    model_access(1'b1, 32'h100, 32'h1122_3344, 1'b0, h, d);
    checks++;
    if (!o.saw_wr || o.mwdata !== 32'h1122_3344 || o.maddr !== 32'h100 || o.en_cycles != 2 || o.stall != 3) begin
      failures++;
      $display("FAIL write_hit wr=%0b wdata=%h addr=%h en=%0d stall=%0d expected 1/11223344/100/2/3",
               o.saw_wr, o.mwdata, o.maddr, o.en_cycles, o.stall);
    end
    access(1'b0, 32'h103, 32'h0, 2, -1, o);
    model_access(1'b0, 32'h103, 32'h0, 1'b0, h, d);
    checks++;
    if (o.rdata !== 32'h1122_3344 || o.stall != 0 || o.saw_rd) begin
      failures++;
      $display("FAIL write_then_load rdata=%h stall=%0d rd=%0b expected 11223344/0/0", o.rdata, o.stall, o.saw_rd);
    end
  endtask

  task automatic test_write_miss();
    obs_t o;
    bit h;
    logic [31:0] d;
    access(1'b1, 32'h200, 32'hCAFE_F00D, 1, -1, o);
    model_access(1'b1, 32'h200, 32'hCAFE_F00D, 1'b0, h, d);
    checks++;
    if (!o.saw_wr || o.mwdata !== 32'hCAFE_F00D || o.maddr !== 32'h200 || o.stall != 2) begin
      failures++;
      $display("FAIL write_miss wr=%0b wdata=%h addr=%h stall=%0d expected 1/cafef00d/200/2",
               o.saw_wr, o.mwdata, o.maddr, o.stall);
    end
    access(1'b0, 32'h100, 32'h0, 1, -1, o);
    model_access(1'b0, 32'h100, 32'h0, 1'b0, h, d);
    checks++;
    if (o.rdata !== 32'h1122_3344 || o.stall != 0) begin
      failures++;
      $display("FAIL no_allocate rdata=%h stall=%0d expected 11223344/0", o.rdata, o.stall);
    end
    access(1'b0, 32'h200, 32'h0, 2, -1, o);
    model_access(1'b0, 32'h200, 32'h0, 1'b0, h, d);
    checks++;
    if (o.rdata !== 32'hCAFE_F00D || o.stall != 3 || !o.saw_rd) begin
      failures++;
      $display("FAIL write_miss_reload rdata=%h stall=%0d rd=%0b expected cafef00d/3/1", o.rdata, o.stall, o.saw_rd);
    end
  endtask

  task automatic test_conflict();
    obs_t o;
    bit h;
    logic [31:0] d;
    apply_reset();
    release_reset();
    access(1'b0, 32'h100, 32'h0, 1, -1, o);
    model_access(1'b0, 32'h100, 32'h0, 1'b0, h, d);
    access(1'b0, 32'h140, 32'h0, 2, -1, o);
    model_access(1'b0, 32'h140, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 3 || o.rdata !== ref_read(32'h140)) begin
      failures++;
      $display("FAIL conflict_load stall=%0d rdata=%h expected 3/%h", o.stall, o.rdata, ref_read(32'h140));
    end
    access(1'b0, 32'h100, 32'h0, 1, -1, o);
    model_access(1'b0, 32'h100, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 2 || o.rdata !== 32'h1122_3344 || miss_count !== 32'd3 || hit_count !== 32'd0) begin
      failures++;
      $display("FAIL conflict_evict stall=%0d rdata=%h miss=%0d hit=%0d expected 2/11223344/3/0",
               o.stall, o.rdata, miss_count, hit_count);
    end
  endtask

  task automatic test_flush_during_miss();
    obs_t o;
    bit h;
    logic [31:0] d;
    access(1'b0, 32'h184, 32'h0, 4, 2, o);
    model_access(1'b0, 32'h184, 32'h0, o.flushed, h, d);
    checks++;
    if (o.rdata !== ref_read(32'h184) || o.stall != 5 || !o.flushed) begin
      failures++;
      $display("FAIL flush_fill rdata=%h stall=%0d expected %h/5", o.rdata, o.stall, ref_read(32'h184));
    end
    access(1'b0, 32'h184, 32'h0, 1, -1, o);
    model_access(1'b0, 32'h184, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 2 || !o.saw_rd) begin
      failures++;
      $display("FAIL flush_clears stall=%0d rd=%0b expected 2/1", o.stall, o.saw_rd);
    end
    access(1'b0, 32'h100, 32'h0, 1, -1, o);
    model_access(1'b0, 32'h100, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 2 || o.rdata !== 32'h1122_3344) begin
      failures++;
      $display("FAIL flush_other_line stall=%0d rdata=%h expected 2/11223344", o.stall, o.rdata);
    end
  endtask

  task automatic test_reset_mid_miss();
    obs_t o;
    bit h;
    logic [31:0] d;
    access(1'b0, 32'h300, 32'h0, 1, -1, o);
    model_access(1'b0, 32'h300, 32'h0, 1'b0, h, d);
    core_addr  = 32'h344;
    core_rd_en = 1'b1;
    mem_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_rd_en !== 1'b1 || core_stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_miss_active rd=%b stall=%b expected 1/1", mem_rd_en, core_stall);
    end
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if (mem_rd_en !== 1'b0 || core_stall !== 1'b0 || miss_count !== 32'd0) begin
      failures++;
      $display("FAIL async_abort rd=%b stall=%b miss=%0d expected 0/0/0", mem_rd_en, core_stall, miss_count);
    end
    model_clear();
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    release_reset();
    access(1'b0, 32'h300, 32'h0, 2, -1, o);
    model_access(1'b0, 32'h300, 32'h0, 1'b0, h, d);
    checks++;
    if (o.stall != 3 || !o.saw_rd || o.rdata !== ref_read(32'h300)) begin
      failures++;
      $display("FAIL post_reset_miss stall=%0d rd=%0b rdata=%h expected 3/1/%h",
               o.stall, o.saw_rd, o.rdata, ref_read(32'h300));
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit h;
    logic [31:0] d, addr, wd;
    bit is_wr;
    int lat, fat, bad;
    bad = 0;
    for (int n = 0; n < 80; n++) begin
      addr  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      addr  = addr | ($urandom_range(0, 1) << 30);
      is_wr = ($urandom_range(0, 2) == 0);
      wd    = $urandom;
      lat   = $urandom_range(1, 4);
      fat   = ($urandom_range(0, 7) == 0) ? 1 : -1;
      access(is_wr, addr, wd, lat, fat, o);
      model_access(is_wr, addr, wd, o.flushed, h, d);
      checks++;
      if (o.timeout || o.stall != ((!is_wr && h) ? 0 : lat + 1) ||
          (!is_wr && (o.rdata !== d || o.saw_rd != !h)) ||
          (is_wr && (o.mwdata !== wd || o.maddr !== {addr[31:2], 2'b00}))) begin
        failures++;
        bad++;
        if (bad < 6)
          $display("FAIL rand_%0d wr=%0b addr=%h stall=%0d rdata=%h expected hit=%0b data=%h lat=%0d",
                   n, is_wr, addr, o.stall, o.rdata, h, d, lat);
      end
    end
    checks++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      failures++;
      $display("FAIL rand_counters hit=%0d miss=%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  initial begin
    core_addr  = 32'h0;
    core_rd_en = 1'b0;
    core_wr_en = 1'b0;
    core_wdata = '0;
    flush      = 1'b0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    rst_b      = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_miss_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_flush_during_miss();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
